// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary high/low PWM drive with programmable dead time,
// phase-locked to an upstream free-running count, with a double-buffered duty.
module pwm_deadtime_gen #(
  parameter int CNT_W = 6,
  parameter int DT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic [DT_W-1:0]  dt_cfg,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             period_strobe,
  output logic             sync_err
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_HI    = 3'd1,
    ST_DT_HL = 3'd2,
    ST_LO    = 3'd3,
    ST_DT_LH = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0]  DT_ZERO  = {DT_W{1'b0}};
  localparam logic [DT_W-1:0]  DT_ONE   = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       ARM_DONE = 2'd2;

  logic [CNT_W-1:0] cnt_q, cnt_prev_q, shadow_q, active_duty_q;
  logic             shadow_full_q, strobe_q, sync_err_q;
  logic             hi_q, hi_d, lo_q, lo_d;
  logic [1:0]       arm_q;
  logic [DT_W-1:0]  dt_q, dt_d;
  state_e           state_q, state_d;
  logic             wrap_s, raw_s, accept_s, disc_s;

  assign wrap_s   = (cnt_prev_q == CNT_MAX) && (cnt_q == CNT_ZERO);
  assign raw_s    = (cnt_q < active_duty_q);
  assign accept_s = duty_valid && !shadow_full_q;
  assign disc_s   = (cnt_q != (cnt_prev_q + CNT_ONE));

  // Count sampling, continuity monitor, wrap strobe and duty double-buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= CNT_ZERO;
      cnt_prev_q    <= CNT_ZERO;
      shadow_q      <= CNT_ZERO;
      active_duty_q <= CNT_ZERO;
      shadow_full_q <= 1'b0;
      strobe_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      arm_q         <= 2'd0;
    end else begin
      cnt_q      <= cnt_in;
      cnt_prev_q <= cnt_q;
      strobe_q   <= wrap_s;
      // The first two compares after reset see reset values, not real history.
      if (arm_q != ARM_DONE) begin
        arm_q <= arm_q + 2'd1;
      end else if (disc_s) begin
        sync_err_q <= 1'b1;
      end
      if (accept_s) begin
        shadow_q      <= duty_in;
        shadow_full_q <= 1'b1;
      end else if (wrap_s && shadow_full_q) begin
        active_duty_q <= shadow_q;
        shadow_full_q <= 1'b0;
      end
    end
  end

  // Output FSM state, dead-time counter and registered drive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      dt_q    <= DT_ZERO;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic; dead-time exit looks at the raw compare at that moment.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (!en) begin
      state_d = ST_OFF;
      dt_d    = DT_ZERO;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (wrap_s) begin
            state_d = raw_s ? ST_HI : ST_LO;
          end else begin
            state_d = ST_OFF;
          end
        end
        ST_HI: begin
          if (!raw_s) begin
            if (dt_cfg == DT_ZERO) begin
              state_d = ST_LO;
            end else begin
              state_d = ST_DT_HL;
              dt_d    = dt_cfg;
            end
          end else begin
            state_d = ST_HI;
          end
        end
        ST_LO: begin
          if (raw_s) begin
            if (dt_cfg == DT_ZERO) begin
              state_d = ST_HI;
            end else begin
              state_d = ST_DT_LH;
              dt_d    = dt_cfg;
            end
          end else begin
            state_d = ST_LO;
          end
        end
        ST_DT_HL, ST_DT_LH: begin
          if (dt_q <= DT_ONE) begin
            state_d = raw_s ? ST_HI : ST_LO;
            dt_d    = DT_ZERO;
          end else begin
            dt_d = dt_q - DT_ONE;
          end
        end
        default: begin
          state_d = ST_OFF;
          dt_d    = DT_ZERO;
        end
      endcase
    end
    hi_d = (state_d == ST_HI);
    lo_d = (state_d == ST_LO);
  end

  assign pwm_hi        = hi_q;
  assign pwm_lo        = lo_q;
  assign period_strobe = strobe_q;
  assign sync_err      = sync_err_q;
  assign duty_ready    = !shadow_full_q;

endmodule
